// File: rtl/apb_delayer_pkg.sv
// rtl/apb_delayer_pkg.sv - shared state type and default widths for the APB timing-scaling delayer
package apb_delayer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 10;
    localparam int RATIO_W   = 8;

endpackage

// File: rtl/apb_win_decode.sv
// rtl/apb_win_decode.sv - combinational address window decoder; lowest hitting window wins
module apb_win_decode
    import apb_delayer_pkg::*;
#(
    parameter int                           NUM_WIN  = 2,
    parameter logic [NUM_WIN*32-1:0]        WIN_BASE = {32'h0F00_0000, 32'hA000_0000},
    parameter logic [NUM_WIN*32-1:0]        WIN_MASK = {32'hFF00_0000, 32'hE000_0000},
    parameter logic [NUM_WIN*RATIO_W-1:0]   WIN_R    = {8'd8, 8'd24},
    parameter int                           IDX_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic [31:0]         paddr,
    output logic                hit,
    output logic [IDX_W-1:0]    index,
    output logic [RATIO_W-1:0]  ratio
);

    // Scan from the top so the lowest matching index is the last assignment.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        ratio = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((paddr & WIN_MASK[i*32 +: 32]) == WIN_BASE[i*32 +: 32]) begin
                hit   = 1'b1;
                index = IDX_W'(i);
                ratio = WIN_R[i*RATIO_W +: RATIO_W];
            end
        end
    end

endmodule

// File: rtl/apb_delayer_multi.sv
// rtl/apb_delayer_multi.sv - per-window APB timing scaler; APB_DELAYER_TIMEOUT_EN adds a downstream timeout
module apb_delayer_multi
    import apb_delayer_pkg::*;
#(
    parameter int                           NUM_WIN  = 2,
    parameter logic [NUM_WIN*32-1:0]        WIN_BASE = {32'h0F00_0000, 32'hA000_0000},
    parameter logic [NUM_WIN*32-1:0]        WIN_MASK = {32'hFF00_0000, 32'hE000_0000},
    parameter logic [NUM_WIN*RATIO_W-1:0]   WIN_R    = {8'd8, 8'd24},
    parameter int                           S_LOG2   = 3,
    parameter int                           CNT_W    = CNT_W_DEF,
    parameter int                           TIMEOUT  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    localparam int IDX_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int XW    = CNT_W + RATIO_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W-1:0]     hold_cnt, hold_nxt;
    logic [IDX_W-1:0]     idx_lat, idx_nxt;
    logic [31:0]          prdata_lat, prdata_nxt;
    logic                 pslverr_lat, pslverr_nxt;

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic [RATIO_W-1:0]   dec_ratio, lat_ratio, r_cur;
    logic [XW-1:0]        n_cyc, prod, t_cyc, extra_w;
    logic [CNT_W-1:0]     extra;
    logic                 gate;

    apb_win_decode #(
        .NUM_WIN  (NUM_WIN),
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (WIN_MASK),
        .WIN_R    (WIN_R),
        .IDX_W    (IDX_W)
    ) u_decode (
        .paddr (in_paddr),
        .hit   (dec_hit),
        .index (dec_idx),
        .ratio (dec_ratio)
    );

    assign out_paddr  = in_paddr;
    assign out_pprot  = in_pprot;
    assign out_pwrite = in_pwrite;
    assign out_pwdata = in_pwdata;
    assign out_pstrb  = in_pstrb;

    // Downstream never sees the master's extended access cycles.
    assign gate        = (state == HOLD) || (state == ERR);
    assign out_psel    = in_psel & ~gate;
    assign out_penable = in_penable & ~gate;

    // Master-visible length T = N*R >> S_LOG2; extra cycles are held after the slave answers.
    assign lat_ratio = WIN_R[int'(idx_lat)*RATIO_W +: RATIO_W];
    assign r_cur     = (state == ACCESS) ? lat_ratio : dec_ratio;
    assign n_cyc     = (state == ACCESS) ? XW'(cnt) + XW'(1) : XW'(1);
    assign prod      = n_cyc * XW'(r_cur);
    assign t_cyc     = prod >> S_LOG2;
    assign extra_w   = (t_cyc > n_cyc) ? t_cyc - n_cyc : '0;
    assign extra     = (extra_w > XW'(CNT_MAX)) ? CNT_MAX : extra_w[CNT_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_cnt    <= '0;
            idx_lat     <= '0;
            prdata_lat  <= '0;
            pslverr_lat <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_nxt;
            idx_lat     <= idx_nxt;
            prdata_lat  <= prdata_nxt;
            pslverr_lat <= pslverr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold_cnt;
        idx_nxt     = idx_lat;
        prdata_nxt  = prdata_lat;
        pslverr_nxt = pslverr_lat;
        in_pready   = out_pready;
        in_prdata   = out_prdata;
        in_pslverr  = out_pslverr;
        case (state)
            IDLE: begin
                if (in_psel && in_penable && dec_hit) begin
                    idx_nxt = dec_idx;
                    if (!out_pready) begin
                        cnt_nxt    = CNT_W'(1);
                        state_nxt  = ACCESS;
                        in_pslverr = 1'b0;
                    end else if (extra != '0) begin
                        prdata_nxt  = out_prdata;
                        pslverr_nxt = out_pslverr;
                        hold_nxt    = extra - CNT_W'(1);
                        state_nxt   = HOLD;
                        in_pready   = 1'b0;
                        in_pslverr  = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (!in_psel) begin
                    state_nxt  = IDLE;
                    in_pready  = 1'b0;
                    in_pslverr = 1'b0;
                end else if (out_pready) begin
                    if (extra == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        prdata_nxt  = out_prdata;
                        pslverr_nxt = out_pslverr;
                        hold_nxt    = extra - CNT_W'(1);
                        state_nxt   = HOLD;
                        in_pready   = 1'b0;
                        in_pslverr  = 1'b0;
                    end
                end else begin
                    in_pready  = 1'b0;
                    in_pslverr = 1'b0;
`ifdef APB_DELAYER_TIMEOUT_EN
                    if (n_cyc >= XW'(TIMEOUT)) begin
                        state_nxt = ERR;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
`else
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
`endif
                end
            end
            HOLD: begin
                in_prdata  = prdata_lat;
                in_pslverr = pslverr_lat;
                if (!in_psel) begin
                    state_nxt = IDLE;
                    in_pready = 1'b0;
                end else if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                    in_pready = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt - CNT_W'(1);
                    in_pready = 1'b0;
                end
            end
`ifdef APB_DELAYER_TIMEOUT_EN
            ERR: begin
                state_nxt  = IDLE;
                in_pready  = 1'b1;
                in_pslverr = 1'b1;
                in_prdata  = '0;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_delayer_multi.sv
// tb/tb_apb_delayer_multi.sv - self-checking bench for apb_delayer_multi (table, corner sequences, random)
module tb_apb_delayer_multi;

    logic        clock;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int checks;
    int failures;

    localparam int LIMIT = 200;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        int          exp_t;
    } vec_t;

    vec_t vecs [8];

    apb_delayer_multi dut (
        .clock       (clock),
        .reset       (reset),
        .in_paddr    (in_paddr),
        .in_psel     (in_psel),
        .in_penable  (in_penable),
        .in_pprot    (in_pprot),
        .in_pwrite   (in_pwrite),
        .in_pwdata   (in_pwdata),
        .in_pstrb    (in_pstrb),
        .in_pready   (in_pready),
        .in_prdata   (in_prdata),
        .in_pslverr  (in_pslverr),
        .out_paddr   (out_paddr),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pprot   (out_pprot),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_pready  (out_pready),
        .out_prdata  (out_prdata),
        .out_pslverr (out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Window 0 (ratio 3.0) is checked before window 1 (ratio 1.0); 0 means no window.
    function automatic int ratio_x8(input logic [31:0] a);
        if ((a & 32'hE000_0000) == 32'hA000_0000) return 24;
        if ((a & 32'hFF00_0000) == 32'h0F00_0000) return 8;
        return 0;
    endfunction

    function automatic int model_t(input logic [31:0] a, input int waits);
        int n;
        int r;
        int t;
        n = waits + 1;
        r = ratio_x8(a);
        if (r == 0) return n;
        t = (n * r) / 8;
        return (t < n) ? n : t;
    endfunction

    // Slave answers on its access cycle waits+1; master must see pready exactly on exp_t.
    task automatic run_xfer(input string name, input logic [31:0] addr, input logic wr, input int waits,
                            input logic [31:0] rdata, input logic err, input int exp_t,
                            input logic [31:0] exp_rdata, input logic exp_err, input int n_down);
        logic done;
        int   f0;
        in_paddr    = addr;
        in_pwrite   = wr;
        in_pwdata   = $urandom;
        in_pstrb    = 4'($urandom);
        in_pprot    = 3'($urandom);
        in_psel     = 1'b1;
        in_penable  = 1'b0;
        out_pready  = 1'b0;
        out_prdata  = $urandom;
        out_pslverr = 1'b0;
        step();
        in_penable = 1'b1;
        done = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            if (k == waits + 1) begin
                out_pready  = 1'b1;
                out_prdata  = rdata;
                out_pslverr = err;
            end else begin
                out_pready  = 1'b0;
                out_prdata  = $urandom;
                out_pslverr = ~err;
            end
            @(negedge clock);
            f0 = failures;
            if (k == 1) begin
                chk({name, " req_pass"}, {out_paddr, out_pwrite, out_pprot, out_pstrb},
                    {in_paddr, in_pwrite, in_pprot, in_pstrb});
                chk({name, " wdata_pass"}, out_pwdata, in_pwdata);
            end
            chk($sformatf("%s cyc%0d {pready,psel,penable}", name, k),
                {in_pready, out_psel, out_penable},
                {(k == exp_t), (k <= n_down), (k <= n_down)});
            if (k == exp_t) begin
                chk({name, " prdata"}, in_prdata, exp_rdata);
                chk({name, " pslverr"}, in_pslverr, exp_err);
                done = 1'b1;
            end
            step();
            if (done || failures != f0) break;
        end
        if (!done && failures == f0) begin
            checks++;
            failures++;
            $display("FAIL %s: no pready within %0d cycles, required on cycle %0d", name, LIMIT, exp_t);
        end
        in_psel    = 1'b0;
        in_penable = 1'b0;
        out_pready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] rd;
        logic        er;
        int          w;
        int          t;

        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h2000_0000, 1'b0, 2, 32'h1111_2222, 1'b0, 3};
        vecs[1] = '{32'hA000_0010, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2] = '{32'hB000_0000, 1'b1, 3, 32'h0BAD_F00D, 1'b1, 12};
        vecs[3] = '{32'h0F00_0004, 1'b0, 3, 32'h5555_AAAA, 1'b0, 4};
        vecs[4] = '{32'hA000_0000, 1'b0, 1, 32'hCAFE_0001, 1'b0, 6};
        vecs[5] = '{32'h0F12_3456, 1'b1, 0, 32'h0000_0042, 1'b1, 1};
        vecs[6] = '{32'hC000_0000, 1'b0, 0, 32'h7777_7777, 1'b0, 1};
        vecs[7] = '{32'h1F00_0000, 1'b0, 4, 32'h1234_ABCD, 1'b1, 5};

        reset       = 1'b1;
        in_paddr    = '0;
        in_psel     = 1'b0;
        in_penable  = 1'b0;
        in_pprot    = '0;
        in_pwrite   = 1'b0;
        in_pwdata   = '0;
        in_pstrb    = '0;
        out_pready  = 1'b1;
        out_prdata  = 32'h1234_5678;
        out_pslverr = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset passthrough {pready,pslverr,psel}", {in_pready, in_pslverr, out_psel}, {1'b1, 1'b1, 1'b0});
        chk("reset prdata", in_prdata, 32'h1234_5678);
        reset      = 1'b0;
        out_pready = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].waits, vecs[i].rdata,
                     vecs[i].err, vecs[i].exp_t, vecs[i].rdata, vecs[i].err, vecs[i].waits + 1);
            step();
        end

        // Reset while holding a response: gating and pready drop at once.
        in_paddr   = 32'hA000_0010;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        step();
        in_penable  = 1'b1;
        out_pready  = 1'b1;
        out_prdata  = 32'hDEAD_BEEF;
        out_pslverr = 1'b0;
        step();
        out_pready = 1'b0;
        out_prdata = 32'h0;
        @(negedge clock);
        chk("hold gating {pready,psel}", {in_pready, out_psel}, {1'b0, 1'b0});
        #1 reset = 1'b1;
        #1;
        chk("reset in hold {pready,psel,penable}", {in_pready, out_psel, out_penable}, {1'b0, 1'b1, 1'b1});
        in_psel    = 1'b0;
        in_penable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step();
        run_xfer("after_reset", 32'hA000_0000, 1'b0, 0, 32'h600D_600D, 1'b0, 3, 32'h600D_600D, 1'b0, 1);
        step();

        // Master abandons the transfer while the slave is still waiting.
        in_paddr   = 32'hA000_0000;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        step();
        in_penable = 1'b1;
        out_pready = 1'b0;
        repeat (3) step();
        in_psel    = 1'b0;
        in_penable = 1'b0;
        @(negedge clock);
        chk("psel drop {pready,psel}", {in_pready, out_psel}, {1'b0, 1'b0});
        step();
        run_xfer("after_drop", 32'hA000_0010, 1'b0, 0, 32'hFEED_0001, 1'b1, 3, 32'hFEED_0001, 1'b1, 1);
        step();

`ifdef APB_DELAYER_TIMEOUT_EN
        run_xfer("timeout", 32'hA000_0000, 1'b0, 1000, 32'hFFFF_FFFF, 1'b0, 17, 32'h0, 1'b1, 16);
        step();
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                1: a = (a & 32'h1FFF_FFFF) | 32'hA000_0000;
                2: a = (a & 32'h00FF_FFFF) | 32'h0F00_0000;
                default: ;
            endcase
            w  = $urandom_range(0, 12);
            rd = $urandom;
            er = 1'($urandom);
            t  = model_t(a, w);
            run_xfer($sformatf("rnd%0d a=%h w=%0d", i, a, w), a, 1'($urandom), w, rd, er, t, rd, er, w + 1);
            repeat ($urandom_range(1, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
